intr_seq_step: RTL and testbench
================================

Name: intr_seq_step

Overview:
- Parametrised successor to the fixed NMI step decoder.
- Owns its own step counter and latches one edge-triggered NMI plus NUM_IRQ level-triggered maskable requests.
- At an instruction boundary it arbitrates among pending requests and runs the push-PC/vector-load microsequence, emitting one-hot step strobes and control pulses.
- Sits between the interrupt pins and the core's control-pulse bus, in parallel with the opcode decoders.

Parameters:
- NUM_IRQ, 4, number of maskable request channels (1..8).
- ACK_STEPS, 3, length of the interrupt-acknowledge M1 phase in steps (2..6).
- NMI_VEC, 8'h66, low byte of the NMI vector.
- IRQ_VEC_BASE, 8'h38, vector low byte for channel 0; channel k uses IRQ_VEC_BASE + 8*k, modulo 256.
- STEP_W, 4, step-counter width; must hold ACK_STEPS+7.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- notNMI  in  1  NMI pin, active low; the falling edge is latched
- IRQ  in  NUM_IRQ  maskable requests, level, active high
- IE  in  1  interrupt-enable flag (IFF1)
- op_end  in  1  current instruction completes this cycle (boundary)
- stall  in  1  wait state; freezes the step counter and the sequence
- XPT  out  STEP_W  current step; 0 = idle
- busy  out  1  sequence in progress
- is_nmi  out  1  the active sequence is the NMI sequence
- ack  out  NUM_IRQ  one-hot accepted channel, held for the whole sequence
- PC_M1  out  1  acknowledge M1 phase (steps 1..ACK_STEPS)
- PR_Dec_SP  out  1  SP decrement strobe
- PC_W  out  3  write-cycle sub-step one-hot (W0, W1, W2)
- PI_SelectDt_PC_high / PI_SelectDt_PC_low  out  1 each  data-bus source select
- notPI_SelectAd_SP  out  1  low while the address bus is driven from SP
- vec_low  out  8  vector low byte, valid in the final step
- Pa_Load_PC  out  1  load PC from vector, final step only
- iff_clear  out  1  one-cycle pulse at step 1
- done  out  1  one-cycle pulse in the final step

Behaviour:
- Let A = ACK_STEPS and L = A+7 (the last step).
- Reset: all latches, XPT and every output are 0; notPI_SelectAd_SP is 1. A reset mid-sequence aborts it with no further strobes.
- NMI latch:
  - set when notNMI was 1 in the previous cycle and is 0 in this one;
  - cleared at step L of an NMI sequence;
  - an edge arriving during a sequence stays latched and is serviced at the next op_end.
- IRQ inputs are sampled, never latched. A channel is eligible when IRQ[k]=1 and IE=1.
- Arbitration happens on a cycle with op_end=1, busy=0 and stall=0:
  - NMI wins over all channels;
  - otherwise the lowest-index eligible channel wins;
  - with nothing pending, XPT stays 0.
  - Acceptance registers is_nmi or ack, and XPT=1 on the next edge.
- Step counter:
  - increments by 1 per cycle unless stall=1;
  - after step L it returns to 0, and busy drops on that same edge;
  - op_end is ignored while busy=1.
- Step strobes are combinational from XPT and the registered channel:
  - PC_M1 = steps 1..A.
  - PR_Dec_SP = steps A+1 and A+4.
  - PI_SelectDt_PC_high = steps A+2..A+4.
  - PI_SelectDt_PC_low = steps A+5..L.
  - notPI_SelectAd_SP = 0 for steps A+2..L.
  - PC_W[0] = steps A+2 and A+5.
  - PC_W[1] = steps A+3 and A+6.
  - PC_W[2] = steps A+4 and L.
  - Pa_Load_PC, done and vec_low are valid at step L; vec_low = NMI_VEC or IRQ_VEC_BASE+8*idx, and 0 otherwise.
  - iff_clear pulses at step 1.
- Stall: outputs hold their step values for as long as stall=1, but iff_clear and done still fire only once.
- Simultaneous events:
  - NMI edge and IRQ in the same op_end cycle: NMI is accepted; the IRQ is re-evaluated at the next boundary.
  - IRQ dropping mid-sequence does not abort the sequence.
  - An NMI edge in step L is latched for the next boundary, not lost.

Decomposition:
- Shared package: step-offset constants (A+1 … A+7 as functions of ACK_STEPS) and the vector computation function.
- Sub-module intr_prio_enc: parametrised lowest-index priority encoder producing a one-hot grant and a valid flag.

Test Plan:
- Reset mid-sequence: RESET=1 at XPT=5 → next cycle XPT=0, busy=0, all strobes 0, NMI latch clear.
- NMI only, A=3: falling edge on notNMI, then op_end → XPT steps 1..10; PC_M1 at 1–3; PR_Dec_SP at 4 and 7; PC_W one-hot 001/010/100 at 5/6/7 and again at 8/9/10; vec_low=8'h66 and Pa_Load_PC at step 10; done exactly once.
- Priority: IRQ=4'b0110, IE=1, NMI edge, op_end → is_nmi=1; next boundary → ack=4'b0010, vec_low=8'h40.
- Masking: IRQ=4'b0001, IE=0, op_end → no sequence; IE=1 then op_end → ack=0001, vec_low=8'h38, iff_clear pulse at step 1.
- Stall: stall=1 for 3 cycles at XPT=6 → XPT held at 6, PC_W held at 010; done still a single pulse; total sequence 13 cycles.
- Edge during sequence: NMI edge at step 10 of an IRQ sequence → latched, and the NMI sequence starts at the next op_end.

Source files
------------

// File: rtl/intr_seq_step_pkg.sv
// Shared types and helpers for the interrupt acknowledge sequencer:
// sequence kinds, step offsets relative to the acknowledge phase, vector math.
package intr_seq_step_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_NMI  = 2'd1,
    SEQ_IRQ  = 2'd2
  } seq_kind_e;

  // Step number k places after the end of the acknowledge M1 phase.
  function automatic int step_after_ack(input int ack_steps, input int k);
    return ack_steps + k;
  endfunction

  // Channel vectors are spaced 8 bytes apart and wrap within the low byte.
  function automatic logic [7:0] irq_vector(input logic [7:0] base, input int idx);
    logic [7:0] offset;
    offset = 8'(idx * 8);
    return base + offset;
  endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-wins priority encoder: one-hot grant plus an any-request flag.
module intr_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         valid
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      if (gi == 0) begin : g_first
        assign grant[gi] = req[gi];
      end else begin : g_rest
        assign grant[gi] = req[gi] & ~(|req[gi-1:0]);
      end
    end
  endgenerate

  assign valid = |req;

endmodule

// File: rtl/intr_seq_step.sv
// Interrupt step sequencer: latches NMI edges, arbitrates at instruction
// boundaries and walks the push-PC / vector-load microsequence.
module intr_seq_step
  import intr_seq_step_pkg::*;
#(
  parameter int          NUM_IRQ      = 4,
  parameter int          ACK_STEPS    = 3,
  parameter logic [7:0]  NMI_VEC      = 8'h66,
  parameter logic [7:0]  IRQ_VEC_BASE = 8'h38,
  parameter int          STEP_W       = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                notNMI,
  input  logic [NUM_IRQ-1:0]  IRQ,
  input  logic                IE,
  input  logic                op_end,
  input  logic                stall,
  output logic [STEP_W-1:0]   XPT,
  output logic                busy,
  output logic                is_nmi,
  output logic [NUM_IRQ-1:0]  ack,
  output logic                PC_M1,
  output logic                PR_Dec_SP,
  output logic [2:0]          PC_W,
  output logic                PI_SelectDt_PC_high,
  output logic                PI_SelectDt_PC_low,
  output logic                notPI_SelectAd_SP,
  output logic [7:0]          vec_low,
  output logic                Pa_Load_PC,
  output logic                iff_clear,
  output logic                done
);

  localparam logic [STEP_W-1:0] S_ONE = STEP_W'(1);
  localparam logic [STEP_W-1:0] S_A0  = STEP_W'(ACK_STEPS);
  localparam logic [STEP_W-1:0] S_A1  = STEP_W'(step_after_ack(ACK_STEPS, 1));
  localparam logic [STEP_W-1:0] S_A2  = STEP_W'(step_after_ack(ACK_STEPS, 2));
  localparam logic [STEP_W-1:0] S_A3  = STEP_W'(step_after_ack(ACK_STEPS, 3));
  localparam logic [STEP_W-1:0] S_A4  = STEP_W'(step_after_ack(ACK_STEPS, 4));
  localparam logic [STEP_W-1:0] S_A5  = STEP_W'(step_after_ack(ACK_STEPS, 5));
  localparam logic [STEP_W-1:0] S_A6  = STEP_W'(step_after_ack(ACK_STEPS, 6));
  localparam logic [STEP_W-1:0] S_L   = STEP_W'(step_after_ack(ACK_STEPS, 7));

  seq_kind_e            kind_q, kind_d;
  logic [STEP_W-1:0]    xpt_q, xpt_d;
  logic [NUM_IRQ-1:0]   ack_q, ack_d;
  logic                 nmi_prev_q, nmi_prev_d;
  logic                 nmi_pend_q, nmi_pend_d;
  logic                 fresh_q, fresh_d;

  logic [NUM_IRQ-1:0]   irq_elig;
  logic [NUM_IRQ-1:0]   irq_grant;
  logic                 irq_valid;
  logic                 nmi_edge;
  logic                 nmi_req;
  logic                 idle;
  logic                 accept;
  logic                 at_last;
  int                   vec_idx;

  assign irq_elig = IRQ & {NUM_IRQ{IE}};

  intr_prio_enc #(.N(NUM_IRQ)) u_prio (
    .req   (irq_elig),
    .grant (irq_grant),
    .valid (irq_valid)
  );

  // An edge seen in the boundary cycle itself already counts as pending.
  assign nmi_edge = nmi_prev_q & ~notNMI;
  assign nmi_req  = nmi_pend_q | nmi_edge;
  assign idle     = (kind_q == SEQ_IDLE);
  assign accept   = op_end & idle & ~stall & (nmi_req | irq_valid);
  assign at_last  = (xpt_q == S_L);

  always_comb begin
    kind_d     = kind_q;
    xpt_d      = xpt_q;
    ack_d      = ack_q;
    nmi_prev_d = notNMI;
    nmi_pend_d = nmi_pend_q;
    fresh_d    = 1'b0;
    case (kind_q)
      SEQ_IDLE: begin
        if (accept) begin
          xpt_d   = S_ONE;
          fresh_d = 1'b1;
          if (nmi_req) begin
            kind_d = SEQ_NMI;
            ack_d  = '0;
          end else begin
            kind_d = SEQ_IRQ;
            ack_d  = irq_grant;
          end
        end
      end
      default: begin
        if (!stall) begin
          fresh_d = 1'b1;
          if (at_last) begin
            xpt_d  = '0;
            kind_d = SEQ_IDLE;
            ack_d  = '0;
            if (kind_q == SEQ_NMI) begin
              nmi_pend_d = 1'b0;
            end
          end else begin
            xpt_d = xpt_q + S_ONE;
          end
        end
      end
    endcase
    // A new edge beats the end-of-sequence clear so it is never dropped.
    if (nmi_edge) begin
      nmi_pend_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      kind_q     <= SEQ_IDLE;
      xpt_q      <= '0;
      ack_q      <= '0;
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
      fresh_q    <= 1'b0;
    end else begin
      kind_q     <= kind_d;
      xpt_q      <= xpt_d;
      ack_q      <= ack_d;
      nmi_prev_q <= nmi_prev_d;
      nmi_pend_q <= nmi_pend_d;
      fresh_q    <= fresh_d;
    end
  end

  always_comb begin
    vec_idx = 0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (ack_q[i]) begin
        vec_idx = i;
      end
    end
  end

  assign XPT    = xpt_q;
  assign busy   = ~idle;
  assign is_nmi = (kind_q == SEQ_NMI);
  assign ack    = ack_q;

  always_comb begin
    PC_M1               = (xpt_q >= S_ONE) && (xpt_q <= S_A0);
    PR_Dec_SP           = (xpt_q == S_A1) || (xpt_q == S_A4);
    PI_SelectDt_PC_high = (xpt_q >= S_A2) && (xpt_q <= S_A4);
    PI_SelectDt_PC_low  = (xpt_q >= S_A5) && (xpt_q <= S_L);
    notPI_SelectAd_SP   = !((xpt_q >= S_A2) && (xpt_q <= S_L));
    PC_W[0]             = (xpt_q == S_A2) || (xpt_q == S_A5);
    PC_W[1]             = (xpt_q == S_A3) || (xpt_q == S_A6);
    PC_W[2]             = (xpt_q == S_A4) || (xpt_q == S_L);
    Pa_Load_PC          = at_last;
    vec_low             = 8'h00;
    if (at_last) begin
      vec_low = is_nmi ? NMI_VEC : irq_vector(IRQ_VEC_BASE, vec_idx);
    end
    // Pulses only on the first cycle of a step, so a stall cannot repeat them.
    iff_clear           = (xpt_q == S_ONE) && fresh_q;
    done                = at_last && fresh_q;
  end

endmodule

// File: tb/tb_intr_seq_step.sv
// Directed bench for intr_seq_step with default parameters; expected
// sequence results are queued at trigger time and retired on done.
module tb_intr_seq_step;

  logic       CLK = 1'b0;
  logic       RESET, notNMI, IE, op_end, stall;
  logic [3:0] IRQ;
  logic [3:0] XPT;
  logic       busy, is_nmi;
  logic [3:0] ack;
  logic       PC_M1, PR_Dec_SP;
  logic [2:0] PC_W;
  logic       PI_SelectDt_PC_high, PI_SelectDt_PC_low, notPI_SelectAd_SP;
  logic [7:0] vec_low;
  logic       Pa_Load_PC, iff_clear, done;
  logic [7:0] strobe_obs;

  typedef struct packed {
    logic       is_nmi;
    logic [3:0] ack;
    logic [7:0] vec;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  intr_seq_step dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .notNMI              (notNMI),
    .IRQ                 (IRQ),
    .IE                  (IE),
    .op_end              (op_end),
    .stall               (stall),
    .XPT                 (XPT),
    .busy                (busy),
    .is_nmi              (is_nmi),
    .ack                 (ack),
    .PC_M1               (PC_M1),
    .PR_Dec_SP           (PR_Dec_SP),
    .PC_W                (PC_W),
    .PI_SelectDt_PC_high (PI_SelectDt_PC_high),
    .PI_SelectDt_PC_low  (PI_SelectDt_PC_low),
    .notPI_SelectAd_SP   (notPI_SelectAd_SP),
    .vec_low             (vec_low),
    .Pa_Load_PC          (Pa_Load_PC),
    .iff_clear           (iff_clear),
    .done                (done)
  );

  always #5 CLK = ~CLK;

  assign strobe_obs = {PC_M1, PR_Dec_SP, PC_W, PI_SelectDt_PC_high,
                       PI_SelectDt_PC_low, notPI_SelectAd_SP};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // {PC_M1, PR_Dec_SP, PC_W[2:0], PC_high, PC_low, notSP} for ACK_STEPS=3.
  function automatic logic [7:0] exp_strobe(input int s);
    case (s)
      1, 2, 3: return 8'b1_0_000_0_0_1;
      4:       return 8'b0_1_000_0_0_1;
      5:       return 8'b0_0_001_1_0_0;
      6:       return 8'b0_0_010_1_0_0;
      7:       return 8'b0_1_100_1_0_0;
      8:       return 8'b0_0_001_0_1_0;
      9:       return 8'b0_0_010_0_1_0;
      10:      return 8'b0_0_100_0_1_0;
      default: return 8'b0_0_000_0_0_1;
    endcase
  endfunction

  // Called one cycle after the accepting edge; follows the sequence to idle.
  task automatic run_seq(input int stall_at, input int stall_len, input int nmi_at, input string name);
    int   step, prev, cycles, left;
    exp_t e;
    logic popped;
    step = 1; prev = 0; cycles = 0; left = stall_len; popped = 1'b0;
    op_end = 1'b0;
    e = (sb.size() != 0) ? sb[0] : '0;
    while (step != 0 && cycles < 40) begin
      check({name, " xpt"},     32'(XPT),        32'(step));
      check({name, " busy"},    32'(busy),       32'(1));
      check({name, " strobes"}, 32'(strobe_obs), 32'(exp_strobe(step)));
      check({name, " is_nmi"},  32'(is_nmi),     32'(e.is_nmi));
      check({name, " ack"},     32'(ack),        32'(e.ack));
      check({name, " vec_low"}, 32'(vec_low),    (step == 10) ? 32'(e.vec) : 32'(0));
      check({name, " load_pc"}, 32'(Pa_Load_PC), 32'(step == 10));
      check({name, " iff_clr"}, 32'(iff_clear),  32'(step == 1 && prev != 1));
      check({name, " done"},    32'(done),       32'(step == 10 && prev != 10));
      if (done && !popped && sb.size() != 0) begin
        popped = 1'b1;
        e = sb.pop_front();
        $display("seq %s: is_nmi=%0d ack=%b vec_low=%h at cycle %0d", name, is_nmi, ack, vec_low, cycles);
      end
      if (step == nmi_at) notNMI = 1'b0;
      prev = step;
      if (step == stall_at && left > 0) begin
        stall = 1'b1;
        left--;
      end else begin
        stall = 1'b0;
        step = (step == 10) ? 0 : step + 1;
      end
      tick();
      cycles++;
    end
    stall = 1'b0;
    check({name, " end xpt"},     32'(XPT),        32'(0));
    check({name, " end busy"},    32'(busy),       32'(0));
    check({name, " end strobes"}, 32'(strobe_obs), 32'(exp_strobe(0)));
    check({name, " length"},      32'(cycles),     32'(10 + stall_len));
    check({name, " retired"},     32'(popped),     32'(1));
  endtask

  initial begin
    RESET = 1'b1; notNMI = 1'b1; IRQ = 4'b0000; IE = 1'b0; op_end = 1'b0; stall = 1'b0;
    tick();
    tick();
    check("reset xpt",     32'(XPT),        32'(0));
    check("reset busy",    32'(busy),       32'(0));
    check("reset strobes", 32'(strobe_obs), 32'(8'b0000_0001));
    check("reset vec",     32'(vec_low),    32'(0));
    check("reset ack",     32'(ack),        32'(0));
    check("reset pulses",  32'({is_nmi, Pa_Load_PC, iff_clear, done}), 32'(0));
    RESET = 1'b0;
    tick();

    // NMI alone: latched edge waits for a boundary.
    notNMI = 1'b0; tick();
    notNMI = 1'b1; tick(); tick();
    check("nmi waits for op_end", 32'(XPT), 32'(0));
    sb.push_back('{1'b1, 4'b0000, 8'h66});
    op_end = 1'b1; tick();
    run_seq(0, 0, 0, "nmi");
    op_end = 1'b1; tick(); op_end = 1'b0;
    check("nmi latch cleared", 32'(XPT), 32'(0));

    // Priority: NMI edge in the boundary cycle beats pending IRQs.
    IRQ = 4'b0110; IE = 1'b1; notNMI = 1'b0; op_end = 1'b1;
    sb.push_back('{1'b1, 4'b0000, 8'h66});
    tick();
    notNMI = 1'b1;
    run_seq(10, 2, 0, "prio_nmi");
    sb.push_back('{1'b0, 4'b0010, 8'h40});
    op_end = 1'b1; tick();
    run_seq(0, 0, 0, "prio_irq");

    // Masking by IE.
    IRQ = 4'b0001; IE = 1'b0; op_end = 1'b1; tick(); op_end = 1'b0;
    check("masked irq", 32'(XPT), 32'(0));
    IE = 1'b1;
    sb.push_back('{1'b0, 4'b0001, 8'h38});
    op_end = 1'b1; tick();
    run_seq(1, 2, 0, "mask_irq");

    // Stall for three cycles at step 6.
    IRQ = 4'b1000;
    sb.push_back('{1'b0, 4'b1000, 8'h50});
    op_end = 1'b1; tick();
    run_seq(6, 3, 0, "stall");

    // NMI edge arriving in the final step of an IRQ sequence.
    IRQ = 4'b0100;
    sb.push_back('{1'b0, 4'b0100, 8'h48});
    op_end = 1'b1; tick();
    run_seq(0, 0, 10, "edge_irq");
    IRQ = 4'b0000; notNMI = 1'b1;
    tick(); tick();
    check("edge nmi held", 32'(XPT), 32'(0));
    sb.push_back('{1'b1, 4'b0000, 8'h66});
    op_end = 1'b1; tick();
    run_seq(0, 0, 0, "edge_nmi");

    // Reset mid-sequence with an NMI latched.
    IRQ = 4'b0001; IE = 1'b1; op_end = 1'b1; tick();
    op_end = 1'b0; notNMI = 1'b0; tick();
    notNMI = 1'b1; tick(); tick(); tick();
    check("pre-reset xpt", 32'(XPT), 32'(5));
    RESET = 1'b1; tick();
    RESET = 1'b0;
    check("abort xpt",     32'(XPT),        32'(0));
    check("abort busy",    32'(busy),       32'(0));
    check("abort strobes", 32'(strobe_obs), 32'(8'b0000_0001));
    check("abort ack",     32'(ack),        32'(0));
    check("abort pulses",  32'({vec_low, Pa_Load_PC, iff_clear, done}), 32'(0));
    IRQ = 4'b0000; op_end = 1'b1; tick(); op_end = 1'b0;
    check("abort nmi clear", 32'(XPT), 32'(0));
    check("scoreboard empty", 32'(sb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
